noc_port_fifo: RTL
==================

Name: noc_port_fifo

Overview:
- Parametrised input-port buffer for the mesh router; one instance per router port (north/south/east/west/local).
- Replaces the fixed 8x8 per-direction FIFOs with configurable data width and depth.
- Adds registered status flags (full, empty, almost_full), an occupancy count, and a read-valid strobe so the switch allocator can apply backpressure.
- Sits between the link receiver (write side) and the crossbar/arbiter (read side).

Parameters:
- DATA_W, 8, flit width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, 6, almost_full asserts when occupancy >= AF_LEVEL; must satisfy 1 <= AF_LEVEL <= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; clears all state while low.
- write  input  1  write request; data_in is captured when the write is accepted.
- data_in  input  DATA_W  write data.
- read  input  1  read request.
- data_out  output  DATA_W  registered read data.
- data_valid  output  1  one-cycle pulse: data_out was updated by an accepted read this cycle.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- almost_full  output  1  occupancy >= AF_LEVEL.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky error flag; exists functionally only with FIFO_ERR_EN.
- underflow  output  1  sticky error flag; exists functionally only with FIFO_ERR_EN.

Behaviour:
- Reset (rst low, asynchronous): data_out=0, data_valid=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, read and write pointers = 0. Storage array is not reset.
- Pointers: clog2(DEPTH) bits each; increment by 1 and wrap DEPTH-1 -> 0 by natural overflow.
- Write acceptance: wr_ok = write & (~full | read).
- Read acceptance: rd_ok = read & ~empty.
- Status flags (full, empty, almost_full) are derived from count at the start of the cycle, i.e. they are registered state.
- Accepted write: mem[wptr] <= data_in; wptr increments.
- Accepted read: data_out <= mem[rptr]; rptr increments; data_valid=1 in the following cycle (one-cycle read latency).
- data_out holds its last value when no read is accepted; data_valid=0 in that case.
- Count update:
  - wr_ok and not rd_ok: count+1.
  - rd_ok and not wr_ok: count-1.
  - Both or neither: count unchanged.
- Full with simultaneous read and write: both are accepted. The oldest entry is read, the new entry is written into the freed slot, and count stays DEPTH.
- Empty with simultaneous read and write: write accepted, read ignored (no bypass). Count becomes 1, data_valid=0, data_out unchanged.
- Write while full without read: dropped; storage, pointers and count unchanged.
- Read while empty: ignored; data_out unchanged, data_valid=0.
- Reset asserted mid-operation: all state clears immediately. Any in-flight accept in that cycle is discarded.
- count, full, empty and almost_full are always mutually consistent; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: FIFO_ERR_EN.
- Defined:
  - overflow is set when write & full & ~read (dropped write).
  - underflow is set when read & empty.
  - Both flags are sticky until reset and have no effect on data-path behaviour.
- Undefined: overflow and underflow are tied to 0, with no associated registers.

Test Plan:
- Reset, then 8 writes 0x01..0x08 with DEPTH=8, AF_LEVEL=6 -> almost_full rises after the 6th accepted write; full=1 and count=8 after the 8th.
- From the full state, write 0xAA with no read -> count stays 8, contents unchanged. With FIFO_ERR_EN: overflow=1.
- From the full state, read+write 0x55 for one cycle -> data_out=0x01 with data_valid=1 the next cycle, count=8. Then 8 reads -> 0x02..0x08, 0x55 in order, empty=1.
- From empty, assert read+write 0x33 -> count=1, data_valid=0. A read next cycle -> data_out=0x33, data_valid=1.
- Wrap check: 20 interleaved write/read pairs with incrementing data -> output order exactly matches input order across pointer wrap; count never exceeds DEPTH.
- Assert rst low mid-burst at count=5 -> count=0, empty=1, data_out=0, data_valid=0 immediately; the first read after release is ignored.

Source files
------------

// File: rtl/noc_port_fifo_if.sv
// Write/read handshake and status bundle between a router input-port buffer and its neighbours.
// master: link receiver / allocator side; slave: the buffer itself.
interface noc_port_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              write;
    logic [DATA_W-1:0] data_in;
    logic              read;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output write, data_in, read,
        input  data_out, data_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  write, data_in, read,
        output data_out, data_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/noc_port_fifo.sv
// Router input-port flit buffer with registered status flags and occupancy count; FIFO_ERR_EN adds sticky overflow/underflow.
// Latency: one cycle from accepted read to data_out/data_valid; no empty bypass.
// Backpressure: writes dropped when full unless a read frees a slot the same cycle; reads ignored when empty.
module noc_port_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic            clk,
    input  logic            rst,
    noc_port_fifo_if.slave  port
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;
    logic              full_q, empty_q, almost_full_q;
    logic              wr_ok, rd_ok;

    // Flags are registered, so a read freeing a slot is what lets a full-cycle write through.
    assign wr_ok = port.write & (~full_q | port.read);
    assign rd_ok = port.read & ~empty_q;

    always_comb begin
        count_nxt = count_q;
        if (wr_ok && !rd_ok)
            count_nxt = count_q + CNT_W'(1);
        else if (rd_ok && !wr_ok)
            count_nxt = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
        end else begin
            count_q       <= count_nxt;
            full_q        <= (count_nxt == CNT_W'(DEPTH));
            empty_q       <= (count_nxt == '0);
            almost_full_q <= (count_nxt >= CNT_W'(AF_LEVEL));
            data_valid_q  <= rd_ok;
            if (wr_ok)
                wptr <= wptr + PTR_W'(1);
            if (rd_ok) begin
                rptr       <= rptr + PTR_W'(1);
                data_out_q <= mem[rptr];
            end
        end
    end

    // Storage is not reset; the rst term keeps a write coinciding with reset from landing.
    always_ff @(posedge clk) begin
        if (wr_ok && rst)
            mem[wptr] <= port.data_in;
    end

`ifdef FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (port.write && full_q && !port.read)
                overflow_q <= 1'b1;
            if (port.read && empty_q)
                underflow_q <= 1'b1;
        end
    end

    assign port.overflow  = overflow_q;
    assign port.underflow = underflow_q;
`else
    assign port.overflow  = 1'b0;
    assign port.underflow = 1'b0;
`endif

    assign port.data_out    = data_out_q;
    assign port.data_valid  = data_valid_q;
    assign port.full        = full_q;
    assign port.empty       = empty_q;
    assign port.almost_full = almost_full_q;
    assign port.count       = count_q;
endmodule
